// File: rtl/inv_shift_row_col_loader.sv
// Column-serial loader for the decrypt path: gathers four 32-bit state columns,
// applies AES InvShiftRows and holds the 128-bit result on a valid/ready output.
module inv_shift_row_col_loader #(
  parameter int COL_W     = 32,
  parameter bit HOLD_LAST = 1'b1
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               flush_i,
  input  logic               col_valid_i,
  output logic               col_ready_o,
  input  logic [COL_W-1:0]   col_data_i,
  output logic               blk_valid_o,
  input  logic               blk_ready_i,
  output logic [4*COL_W-1:0] blk_data_o,
  output logic [1:0]         col_cnt_o,
  output logic               done_o
);

  localparam int BLK_W = 4 * COL_W;

  if (COL_W != 32) begin : g_bad_col_w
    $error("inv_shift_row_col_loader: COL_W must be 32");
  end

  typedef enum logic [1:0] {IDLE, FILL, FULL} state_e;

  state_e                  state_q, state_d;
  logic                    col_ready_q, col_ready_d;
  logic                    blk_valid_q, blk_valid_d;
  logic [BLK_W-1:0]        blk_data_q, blk_data_d;
  logic [1:0]              col_cnt_q, col_cnt_d;
  logic                    done_q, done_d;
  logic [2:0][COL_W-1:0]   buf_q, buf_d;
  logic [BLK_W-1:0]        blk_rel;

  // Byte k of the state sits at [127-8k -: 8]; columns are {b4c, b4c+1, b4c+2, b4c+3}.
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [7:0] b [16];
    for (int k = 0; k < 16; k++) b[k] = s[127-8*k -: 8];
    return {b[0],  b[13], b[10], b[7],
            b[4],  b[1],  b[14], b[11],
            b[8],  b[5],  b[2],  b[15],
            b[12], b[9],  b[6],  b[3]};
  endfunction

  // Value blk_data takes when a block is released or aborted.
  assign blk_rel = HOLD_LAST ? blk_data_q : '0;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      col_ready_q <= 1'b0;
      blk_valid_q <= 1'b0;
      blk_data_q  <= '0;
      col_cnt_q   <= '0;
      done_q      <= 1'b0;
      buf_q       <= '0;
    end else begin
      state_q     <= state_d;
      col_ready_q <= col_ready_d;
      blk_valid_q <= blk_valid_d;
      blk_data_q  <= blk_data_d;
      col_cnt_q   <= col_cnt_d;
      done_q      <= done_d;
      buf_q       <= buf_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    col_ready_d = col_ready_q;
    blk_valid_d = blk_valid_q;
    blk_data_d  = blk_data_q;
    col_cnt_d   = col_cnt_q;
    done_d      = 1'b0;
    buf_d       = buf_q;
    if (flush_i) begin
      // Abort wins over both handshakes on the same edge.
      state_d     = FILL;
      col_cnt_d   = '0;
      blk_valid_d = 1'b0;
      col_ready_d = 1'b1;
      blk_data_d  = blk_rel;
    end else begin
      case (state_q)
        IDLE: begin
          state_d     = FILL;
          col_ready_d = 1'b1;
        end
        FILL: begin
          if (col_valid_i && col_ready_q) begin
            if (col_cnt_q == 2'd3) begin
              blk_data_d  = inv_shift_rows({buf_q[0], buf_q[1], buf_q[2], col_data_i});
              blk_valid_d = 1'b1;
              col_ready_d = 1'b0;
              col_cnt_d   = '0;
              state_d     = FULL;
            end else begin
              buf_d[col_cnt_q] = col_data_i;
              col_cnt_d        = col_cnt_q + 2'd1;
            end
          end
        end
        FULL: begin
          if (blk_valid_q && blk_ready_i) begin
            done_d      = 1'b1;
            blk_valid_d = 1'b0;
            col_ready_d = 1'b1;
            blk_data_d  = blk_rel;
            state_d     = FILL;
          end
        end
        default: begin
          state_d     = IDLE;
          col_ready_d = 1'b0;
          blk_valid_d = 1'b0;
        end
      endcase
    end
  end

  assign col_ready_o = col_ready_q;
  assign blk_valid_o = blk_valid_q;
  assign blk_data_o  = blk_data_q;
  assign col_cnt_o   = col_cnt_q;
  assign done_o      = done_q;

endmodule

// File: tb/tb_inv_shift_row_col_loader.sv
// Bench for inv_shift_row_col_loader: directed handshake/flush/reset cases
// followed by a randomized round trip against a byte-matrix reference model.
module tb_inv_shift_row_col_loader;

  logic         clk_i = 1'b0;
  logic         reset_i, flush_i, col_valid_i, blk_ready_i;
  logic [31:0]  col_data_i;
  logic         col_ready_o, blk_valid_o, done_o;
  logic [127:0] blk_data_o;
  logic [1:0]   col_cnt_o;

  int n_chk = 0;
  int n_err = 0;

  inv_shift_row_col_loader #(.COL_W(32), .HOLD_LAST(1'b1)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .flush_i(flush_i),
    .col_valid_i(col_valid_i), .col_ready_o(col_ready_o), .col_data_i(col_data_i),
    .blk_valid_o(blk_valid_o), .blk_ready_i(blk_ready_i), .blk_data_o(blk_data_o),
    .col_cnt_o(col_cnt_o), .done_o(done_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: state as a 4x4 byte matrix m[row][col]; row r is rotated by r.
  function automatic logic [127:0] shift_model(input logic [127:0] s, input bit inverse);
    logic [7:0]   m [4][4];
    logic [127:0] r;
    for (int c = 0; c < 4; c++)
      for (int w = 0; w < 4; w++) m[w][c] = s[127-32*c-8*w -: 8];
    r = '0;
    for (int c = 0; c < 4; c++)
      for (int w = 0; w < 4; w++)
        r[127-32*c-8*w -: 8] = inverse ? m[w][(c-w+4)%4] : m[w][(c+w)%4];
    return r;
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic send_cols(input logic [127:0] blk, input int n);
    for (int i = 0; i < n; i++) begin
      col_valid_i = 1'b1;
      col_data_i  = blk[127-32*i -: 32];
      tick();
    end
    col_valid_i = 1'b0;
  endtask

  logic [127:0] a, b, held;
  logic [31:0]  cap [4];
  logic [127:0] expq [$];
  logic [127:0] srcq [$];

  initial begin
    reset_i = 1'b1; flush_i = 1'b0; col_valid_i = 1'b0; blk_ready_i = 1'b0; col_data_i = '0;
    repeat (3) tick();
    chk("rst_col_ready", col_ready_o, 0);
    chk("rst_blk_valid", blk_valid_o, 0);
    chk("rst_blk_data",  blk_data_o,  0);
    chk("rst_col_cnt",   col_cnt_o,   0);
    chk("rst_done",      done_o,      0);
    reset_i = 1'b0;
    tick();
    chk("idle_to_fill_ready", col_ready_o, 1);

    // T1 basic
    a = 128'h00010203_04050607_08090a0b_0c0d0e0f;
    blk_ready_i = 1'b1;
    send_cols(a, 4);
    chk("t1_blk_valid", blk_valid_o, 1);
    chk("t1_blk_data",  blk_data_o, 128'h000d0a07_04010e0b_0805020f_0c090603);
    chk("t1_model",     shift_model(a, 1'b1), 128'h000d0a07_04010e0b_0805020f_0c090603);
    chk("t1_col_ready", col_ready_o, 0);
    tick();
    chk("t1_done",      done_o, 1);
    chk("t1_valid_off", blk_valid_o, 0);
    tick();
    chk("t1_done_once", done_o, 0);

    // T2 backpressure with ignored extra columns
    blk_ready_i = 1'b0;
    send_cols(a, 4);
    held = shift_model(a, 1'b1);
    for (int i = 0; i < 10; i++) begin
      col_valid_i = 1'b1;
      col_data_i  = $urandom;
      tick();
      chk("t2_blk_data_stable", blk_data_o, held);
      chk("t2_blk_valid_stable", blk_valid_o, 1);
    end
    chk("t2_col_ready", col_ready_o, 0);
    chk("t2_col_cnt",   col_cnt_o, 0);
    col_valid_i = 1'b0; blk_ready_i = 1'b1;
    tick();
    chk("t2_done",      done_o, 1);
    chk("t2_col_ready_back", col_ready_o, 1);
    chk("t2_hold_last", blk_data_o, held);

    // T3 gapped input
    blk_ready_i = 1'b0;
    begin
      bit pat [7] = '{1, 0, 0, 1, 1, 0, 1};
      int ncap = 0;
      for (int i = 0; i < 7; i++) begin
        col_valid_i = pat[i];
        col_data_i  = $urandom;
        if (pat[i]) cap[ncap] = col_data_i;
        tick();
        if (pat[i]) ncap = (ncap + 1) % 4;
        chk($sformatf("t3_col_cnt_%0d", i), col_cnt_o, ncap);
      end
      col_valid_i = 1'b0;
      chk("t3_blk_valid", blk_valid_o, 1);
      chk("t3_blk_data", blk_data_o, shift_model({cap[0], cap[1], cap[2], cap[3]}, 1'b1));
    end
    blk_ready_i = 1'b1;
    tick();
    chk("t3_done", done_o, 1);

    // T4 flush mid-fill and in FULL
    blk_ready_i = 1'b0;
    a = {$urandom, $urandom, $urandom, $urandom};
    b = {$urandom, $urandom, $urandom, $urandom};
    send_cols(a, 2);
    flush_i = 1'b1; col_valid_i = 1'b1; col_data_i = a[63:32];
    tick();
    flush_i = 1'b0; col_valid_i = 1'b0;
    chk("t4_flush_cnt",   col_cnt_o, 0);
    chk("t4_flush_valid", blk_valid_o, 0);
    chk("t4_flush_ready", col_ready_o, 1);
    send_cols(b, 4);
    chk("t4_new_block", blk_data_o, shift_model(b, 1'b1));
    flush_i = 1'b1; blk_ready_i = 1'b1;
    tick();
    flush_i = 1'b0;
    chk("t4_full_flush_valid", blk_valid_o, 0);
    chk("t4_full_flush_done",  done_o, 0);
    chk("t4_full_flush_ready", col_ready_o, 1);
    tick();
    chk("t4_no_late_done", done_o, 0);

    // T5 async reset mid-block and in FULL
    send_cols(a, 3);
    #2 reset_i = 1'b1;
    #1;
    chk("t5a_col_ready", col_ready_o, 0);
    chk("t5a_col_cnt",   col_cnt_o, 0);
    chk("t5a_blk_data",  blk_data_o, 0);
    reset_i = 1'b0;
    tick();
    chk("t5a_ready_back", col_ready_o, 1);
    blk_ready_i = 1'b0;
    send_cols(a, 4);
    chk("t5b_pre_valid", blk_valid_o, 1);
    #2 reset_i = 1'b1;
    #1;
    chk("t5b_blk_valid", blk_valid_o, 0);
    chk("t5b_blk_data",  blk_data_o, 0);
    chk("t5b_col_ready", col_ready_o, 0);
    chk("t5b_done",      done_o, 0);
    reset_i = 1'b0;
    tick();
    chk("t5b_ready_back", col_ready_o, 1);

    // T6 random round trip with stalls on both sides
    begin
      int blocks = 0, cycles = 0, ncap = 0;
      bit acc_c, acc_b;
      col_valid_i = 1'b0;
      while (blocks < 1000 && cycles < 60000) begin
        if (!col_valid_i && $urandom_range(0, 9) < 7) begin
          col_valid_i = 1'b1;
          col_data_i  = $urandom;
        end
        blk_ready_i = $urandom_range(0, 1);
        acc_c = col_valid_i && col_ready_o;
        acc_b = blk_valid_o && blk_ready_i;
        if (acc_b) begin
          chk("t6_blk_data", blk_data_o, expq.size() ? expq.pop_front() : 128'hx);
          chk("t6_fwd_roundtrip", shift_model(blk_data_o, 1'b0),
              srcq.size() ? srcq.pop_front() : 128'hx);
        end
        tick();
        cycles++;
        if (acc_c) begin
          cap[ncap] = col_data_i;
          ncap++;
          if (ncap == 4) begin
            srcq.push_back({cap[0], cap[1], cap[2], cap[3]});
            expq.push_back(shift_model({cap[0], cap[1], cap[2], cap[3]}, 1'b1));
            ncap = 0;
          end
          col_valid_i = 1'b0;
        end
        if (acc_b) begin
          chk("t6_done", done_o, 1);
          blocks++;
        end
      end
      if (blocks < 1000) chk("t6_timeout_blocks", blocks, 1000);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
